// File: rtl/hacd_pkg.sv
// Shared hawk types: CPU override packet from the control unit and the ATT lookup request.
// Default AXI4 widths apply when the HACD_AXI4_* macros are not supplied by the build.
`ifndef HACD_AXI4_DATA_WIDTH
`define HACD_AXI4_DATA_WIDTH 64
`endif
`ifndef HACD_AXI4_ADDR_WIDTH
`define HACD_AXI4_ADDR_WIDTH 32
`endif
`ifndef HACD_AXI4_ID_WIDTH
`define HACD_AXI4_ID_WIDTH 4
`endif
`ifndef HACD_AXI4_USER_WIDTH
`define HACD_AXI4_USER_WIDTH 2
`endif

package hacd_pkg;
    localparam int HACD_PAGE_SHIFT = 12;
    localparam int HACD_ADDR_W     = `HACD_AXI4_ADDR_WIDTH;
    localparam int HACD_PPN_W      = HACD_ADDR_W - HACD_PAGE_SHIFT;

    typedef struct packed {
        logic                   allow_access;
        logic [HACD_ADDR_W-1:0] ppa;
    } hawk_cpu_ovrd_pkt_t;

    typedef struct packed {
        logic                  valid;
        logic [HACD_PPN_W-1:0] hppa;
    } cpu_reqpkt_t;

    // Physical page from ppa, in-page offset from the original address.
    function automatic logic [HACD_ADDR_W-1:0] hacd_page_merge(
        input logic [HACD_ADDR_W-1:0] ppa,
        input logic [HACD_ADDR_W-1:0] addr
    );
        logic [HACD_ADDR_W-1:0] mask;
        mask = {{HACD_PPN_W{1'b1}}, {HACD_PAGE_SHIFT{1'b0}}};
        return (ppa & mask) | (addr & ~mask);
    endfunction
endpackage

// File: rtl/hawk_axi_w_gate.sv
// W-channel gate for the write stall bridge: passes beats only while the AW has been issued,
// counts beats and flags wlast against the latched awlen in simulation.
module hawk_axi_w_gate
    import hacd_pkg::*;
#(
    parameter int DATA_WIDTH = `HACD_AXI4_DATA_WIDTH,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_active,
    input  logic [7:0]            i_awlen,
    input  logic [DATA_WIDTH-1:0] i_s_wdata,
    input  logic [STRB_WIDTH-1:0] i_s_wstrb,
    input  logic                  i_s_wlast,
    input  logic                  i_s_wvalid,
    output logic                  o_s_wready,
    output logic [DATA_WIDTH-1:0] o_m_wdata,
    output logic [STRB_WIDTH-1:0] o_m_wstrb,
    output logic                  o_m_wlast,
    output logic                  o_m_wvalid,
    input  logic                  i_m_wready,
    output logic                  o_burst_done
);
    logic       w_hs;
    logic [7:0] r_beat_cnt;

    assign o_m_wvalid   = i_active && i_s_wvalid;
    assign o_s_wready   = i_active && i_m_wready;
    assign o_m_wdata    = i_s_wdata;
    assign o_m_wstrb    = i_s_wstrb;
    assign o_m_wlast    = i_s_wlast;
    assign w_hs         = o_m_wvalid && i_m_wready;
    assign o_burst_done = w_hs && i_s_wlast;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_beat_cnt <= 8'd0;
        end else if (w_hs) begin
            r_beat_cnt <= i_s_wlast ? 8'd0 : r_beat_cnt + 8'd1;
        end
    end

    // The wlast beat must be beat number awlen (zero-based) of the burst.
    a_wlast_beats: assert property (@(posedge clk) disable iff (rst)
        o_burst_done |-> (r_beat_cnt == i_awlen));
endmodule

// File: rtl/hawk_cpu_stall_wr.sv
// CPU-side AXI4 write bridge: holds each AW until hawk resolves the ATT lookup, then issues the
// translated AW and gates the W burst through. Optional HAWK_CPU_WR_BWAIT_EN waits for B too.
module hawk_cpu_stall_wr
    import hacd_pkg::*;
#(
    parameter int DATA_WIDTH    = `HACD_AXI4_DATA_WIDTH,
    parameter int ADDR_WIDTH    = `HACD_AXI4_ADDR_WIDTH,
    parameter int STRB_WIDTH    = DATA_WIDTH / 8,
    parameter int ID_WIDTH      = `HACD_AXI4_ID_WIDTH,
    parameter int AWUSER_ENABLE = 1,
    parameter int AWUSER_WIDTH  = `HACD_AXI4_USER_WIDTH,
    parameter int BUSER_WIDTH   = `HACD_AXI4_USER_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  hawk_cpu_ovrd_pkt_t      hawk_cpu_ovrd_pkt,
    output cpu_reqpkt_t             cpu_reqpkt,
    input  logic                    hawk_inactive,
    input  logic [ID_WIDTH-1:0]     s_axi_awid,
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [7:0]              s_axi_awlen,
    input  logic [2:0]              s_axi_awsize,
    input  logic [1:0]              s_axi_awburst,
    input  logic                    s_axi_awlock,
    input  logic [3:0]              s_axi_awcache,
    input  logic [2:0]              s_axi_awprot,
    input  logic [3:0]              s_axi_awqos,
    input  logic [3:0]              s_axi_awregion,
    input  logic [AWUSER_WIDTH-1:0] s_axi_awuser,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [STRB_WIDTH-1:0]   s_axi_wstrb,
    input  logic                    s_axi_wlast,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    output logic [ID_WIDTH-1:0]     s_axi_bid,
    output logic [1:0]              s_axi_bresp,
    output logic [BUSER_WIDTH-1:0]  s_axi_buser,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    output logic [ID_WIDTH-1:0]     m_axi_awid,
    output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [7:0]              m_axi_awlen,
    output logic [2:0]              m_axi_awsize,
    output logic [1:0]              m_axi_awburst,
    output logic                    m_axi_awlock,
    output logic [3:0]              m_axi_awcache,
    output logic [2:0]              m_axi_awprot,
    output logic [3:0]              m_axi_awqos,
    output logic [3:0]              m_axi_awregion,
    output logic [AWUSER_WIDTH-1:0] m_axi_awuser,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    output logic [DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [STRB_WIDTH-1:0]   m_axi_wstrb,
    output logic                    m_axi_wlast,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    input  logic [ID_WIDTH-1:0]     m_axi_bid,
    input  logic [1:0]              m_axi_bresp,
    input  logic [BUSER_WIDTH-1:0]  m_axi_buser,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready
);
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ISSUE,
`ifdef HAWK_CPU_WR_BWAIT_EN
        ST_DATA,
        ST_BRESP
`else
        ST_DATA
`endif
    } state_t;

    state_t                  r_state;
    logic                    r_awready;
    logic                    r_awvalid;
    logic [ID_WIDTH-1:0]     r_awid;
    logic [ADDR_WIDTH-1:0]   r_awaddr;
    logic [7:0]              r_awlen;
    logic [2:0]              r_awsize;
    logic [1:0]              r_awburst;
    logic                    r_awlock;
    logic [3:0]              r_awcache;
    logic [2:0]              r_awprot;
    logic [3:0]              r_awqos;
    logic [3:0]              r_awregion;
    logic [AWUSER_WIDTH-1:0] r_awuser;
    logic                    w_aw_hs;
    logic                    w_allow;
    logic                    w_burst_done;

    assign w_aw_hs = s_axi_awvalid && r_awready;
    assign w_allow = hawk_cpu_ovrd_pkt.allow_access;

    // NOTE: sequential state uses <= so every register samples pre-edge values, whatever the statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_awready <= 1'b0;
            r_awvalid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_aw_hs) begin
                        r_awready <= 1'b0;
                        r_awvalid <= hawk_inactive;
                        r_state   <= hawk_inactive ? ST_ISSUE : ST_WAIT;
                    end else begin
                        r_awready <= !r_awvalid;
                    end
                end
                ST_WAIT: begin
                    if (w_allow) begin
                        r_awvalid <= 1'b1;
                        r_state   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (m_axi_awready) begin
                        r_awvalid <= 1'b0;
                        r_state   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_burst_done) begin
`ifdef HAWK_CPU_WR_BWAIT_EN
                        r_state   <= ST_BRESP;
`else
                        r_state   <= ST_IDLE;
                        r_awready <= 1'b1;
`endif
                    end
                end
`ifdef HAWK_CPU_WR_BWAIT_EN
                ST_BRESP: begin
                    if (m_axi_bvalid && m_axi_bready) begin
                        r_state   <= ST_IDLE;
                        r_awready <= 1'b1;
                    end
                end
`endif
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // NOTE: the AW payload is qualified by the valid/state registers, so it needs no reset.
    always_ff @(posedge clk) begin
        if (w_aw_hs) begin
            r_awid     <= s_axi_awid;
            r_awaddr   <= s_axi_awaddr;
            r_awlen    <= s_axi_awlen;
            r_awsize   <= s_axi_awsize;
            r_awburst  <= s_axi_awburst;
            r_awlock   <= s_axi_awlock;
            r_awcache  <= s_axi_awcache;
            r_awprot   <= s_axi_awprot;
            r_awqos    <= s_axi_awqos;
            r_awregion <= s_axi_awregion;
            r_awuser   <= s_axi_awuser;
        end else if (r_state == ST_WAIT && w_allow) begin
            r_awaddr   <= hacd_page_merge(hawk_cpu_ovrd_pkt.ppa, r_awaddr);
        end
    end

    always_comb begin
        cpu_reqpkt.valid = (r_state == ST_WAIT) && !w_allow;
        cpu_reqpkt.hppa  = r_awaddr[ADDR_WIDTH-1:HACD_PAGE_SHIFT];
    end

    assign s_axi_awready  = r_awready;
    assign m_axi_awvalid  = r_awvalid;
    assign m_axi_awid     = r_awid;
    assign m_axi_awaddr   = r_awaddr;
    assign m_axi_awlen    = r_awlen;
    assign m_axi_awsize   = r_awsize;
    assign m_axi_awburst  = r_awburst;
    assign m_axi_awlock   = r_awlock;
    assign m_axi_awcache  = r_awcache;
    assign m_axi_awprot   = r_awprot;
    assign m_axi_awqos    = r_awqos;
    assign m_axi_awregion = r_awregion;
    assign m_axi_awuser   = (AWUSER_ENABLE != 0) ? r_awuser : '0;

    hawk_axi_w_gate #(
        .DATA_WIDTH (DATA_WIDTH),
        .STRB_WIDTH (STRB_WIDTH)
    ) u_w_gate (
        .clk          (clk),
        .rst          (rst),
        .i_active     (r_state == ST_DATA),
        .i_awlen      (r_awlen),
        .i_s_wdata    (s_axi_wdata),
        .i_s_wstrb    (s_axi_wstrb),
        .i_s_wlast    (s_axi_wlast),
        .i_s_wvalid   (s_axi_wvalid),
        .o_s_wready   (s_axi_wready),
        .o_m_wdata    (m_axi_wdata),
        .o_m_wstrb    (m_axi_wstrb),
        .o_m_wlast    (m_axi_wlast),
        .o_m_wvalid   (m_axi_wvalid),
        .i_m_wready   (m_axi_wready),
        .o_burst_done (w_burst_done)
    );

    assign s_axi_bid    = m_axi_bid;
    assign s_axi_bresp  = m_axi_bresp;
    assign s_axi_buser  = m_axi_buser;
    assign s_axi_bvalid = m_axi_bvalid;
    assign m_axi_bready = s_axi_bready;
endmodule
